// File: rtl/uart_char_rx_if.sv
// uart_char_rx_if: serial line in, character strobe and status out
interface uart_char_rx_if;
  logic       rx;
  logic [6:0] char;
  logic       char_valid;
  logic       frame_err;
  logic       busy;
  modport master (output rx, input char, char_valid, frame_err, busy);
  modport slave  (input rx, output char, char_valid, frame_err, busy);
endinterface

// File: rtl/uart_char_rx.sv
// uart_char_rx: 8N1 oversampling receiver delivering 7-bit characters
module uart_char_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input logic          clk,
  input logic          rst_n,
  uart_char_rx_if.slave u
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
  state_t           state_q, state_d;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [6:0]       char_q, char_d;
  logic             valid_q, valid_d, err_q, err_d;
  logic             rx_s;
  assign rx_s         = sync_q[1];
  assign u.char       = char_q;
  assign u.char_valid = valid_q;
  assign u.frame_err  = err_q;
  assign u.busy       = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    char_d  = char_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = rx_s ? IDLE : START;
      end
      START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt_q == FULL) begin
        cnt_d   = '0;
        shift_d = {rx_s, shift_q[7:1]};
        idx_d   = idx_q + 3'd1;
        state_d = (idx_q == 3'd7) ? STOP : DATA;
      end
      // Leaving at mid-stop-bit lets a directly following start bit be caught
      STOP: if (cnt_q == FULL) begin
        cnt_d   = '0;
        char_d  = rx_s ? shift_q[6:0] : char_q;
        valid_d = rx_s;
        err_d   = !rx_s;
        state_d = rx_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        cnt_d   = '0;
        state_d = rx_s ? IDLE : WAIT_IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      char_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], u.rx};
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_uart_char_rx.sv
// tb_uart_char_rx: directed and random frames against a queue-based line model
module tb_uart_char_rx;
  localparam int C   = 16;
  localparam int LAT = 2 + C / 2 + 9 * C + 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int nvalid = 0;
  int nerr = 0;
  int prev_char = 0;
  int exp_q[$];
  int st_q[$];
  uart_char_rx_if u ();
  uart_char_rx #(.CLKS_PER_BIT(C), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .u(u));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input int n);
    u.rx = v;
    repeat (n) @(negedge clk);
  endtask
  // Good frames expect the low 7 bits; a low stop bit expects an error (0x80)
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    exp_q.push_back(stop_ok ? int'(b[6:0]) : 32'h80);
    st_q.push_back(cyc);
    drive(1'b0, C);
    for (int i = 0; i < 8; i++) drive(b[i], C);
    drive(stop_ok, C);
  endtask
  always @(negedge clk) begin
    if (!rst_n) prev_char = 0;
    else begin
      if (u.char_valid || u.frame_err) begin
        int got, lat;
        got = u.frame_err ? 32'h80 : int'(u.char);
        if (exp_q.size() == 0) chk("unexpected_evt", got, 32'hff);
        else begin
          chk("evt", got, exp_q.pop_front());
          lat = cyc - st_q.pop_front();
          chk("latency_ok", int'(lat >= LAT - 1 && lat <= LAT + 1), 1);
        end
        chk("excl", int'(u.char_valid & u.frame_err), 0);
        if (u.char_valid) begin
          chk("busy_on_valid", int'(u.busy), 0);
          nvalid++;
        end
        if (u.frame_err) nerr++;
      end
      if (!u.char_valid) chk("char_hold", int'(u.char), prev_char);
      prev_char = int'(u.char);
    end
  end
  initial begin
    int v0, e0;
    u.rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_char", int'(u.char), 0);
    chk("rst_valid", int'(u.char_valid), 0);
    chk("rst_err", int'(u.frame_err), 0);
    chk("rst_busy", int'(u.busy), 0);
    rst_n = 1'b1;
    drive(1'b1, C);
    send_frame(8'h41, 1'b1);
    drive(1'b1, C);
    chk("a_char", int'(u.char), 'h41);
    chk("a_busy", int'(u.busy), 0);
    chk("a_nvalid", nvalid, 1);
    chk("a_nerr", nerr, 0);
    send_frame(8'hC1, 1'b1);
    drive(1'b1, C);
    chk("c1_char", int'(u.char), 'h41);
    chk("c1_nvalid", nvalid, 2);
    send_frame(8'h35, 1'b0);
    drive(1'b0, 40);
    chk("brk_busy", int'(u.busy), 1);
    chk("brk_nerr", nerr, 1);
    chk("brk_nvalid", nvalid, 2);
    chk("brk_char", int'(u.char), 'h41);
    drive(1'b1, 4);
    chk("brk_idle", int'(u.busy), 0);
    drive(1'b1, C);
    v0 = nvalid;
    e0 = nerr;
    drive(1'b0, 4);
    u.rx = 1'b1;
    for (int i = 0; i < C / 2 + 3 && u.busy; i++) @(negedge clk);
    chk("glitch_busy", int'(u.busy), 0);
    drive(1'b1, 2 * C);
    chk("glitch_nvalid", nvalid, v0);
    chk("glitch_nerr", nerr, e0);
    send_frame(8'h31, 1'b1);
    send_frame(8'h32, 1'b1);
    send_frame(8'h33, 1'b1);
    drive(1'b1, C);
    chk("b2b_nvalid", nvalid, v0 + 3);
    chk("b2b_char", int'(u.char), 'h33);
    v0 = nvalid;
    drive(1'b0, C);
    for (int i = 0; i < 4; i++) drive(i[0], C);
    drive(1'b1, C / 2);
    rst_n = 1'b0;
    drive(1'b1, 3);
    rst_n = 1'b1;
    drive(1'b1, 2);
    chk("abort_char", int'(u.char), 0);
    chk("abort_busy", int'(u.busy), 0);
    drive(1'b1, C);
    chk("abort_nvalid", nvalid, v0);
    send_frame(8'h2A, 1'b1);
    drive(1'b1, C);
    chk("post_rst_char", int'(u.char), 'h2A);
    chk("post_rst_nvalid", nvalid, v0 + 1);
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      logic ok;
      b  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      send_frame(b, ok);
      if (!ok) drive(1'b0, $urandom_range(0, 20));
      drive(1'b1, ok ? $urandom_range(0, 2 * C) : $urandom_range(4, 2 * C));
    end
    drive(1'b1, 2 * C);
    chk("pending", exp_q.size(), 0);
    chk("final_busy", int'(u.busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
